// File: rtl/iob_cache_write_buffer.sv
// Write buffer between the cache front end and the write channel.
// A small show-ahead FIFO: the head entry is presented combinationally on out_*.
// A push into a full buffer is accepted only if the head is leaving in the
// same cycle. Otherwise the push is dropped and a sticky overflow flag is raised.
module iob_cache_write_buffer #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH_W = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset,
  input  logic                                  push_i,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]    push_addr_i,
  input  logic [DATA_W-1:0]                     push_wdata_i,
  input  logic [DATA_W/8-1:0]                   push_wstrb_i,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [DEPTH_W:0]                      level_o,
  output logic                                  overflow_o,
  output logic                                  out_valid_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    out_addr_o,
  output logic [DATA_W-1:0]                     out_wdata_o,
  output logic [DATA_W/8-1:0]                   out_wstrb_o,
  input  logic                                  out_ready_i
);

  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned NBYTES_W = $clog2(NBYTES);
  localparam int unsigned WADDR_W  = ADDR_W - NBYTES_W;
  localparam int unsigned ENTRY_W  = WADDR_W + DATA_W + NBYTES;
  localparam int unsigned DEPTH    = 2 ** DEPTH_W;

  localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W + 1)'(DEPTH);
  localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  // Storage and bookkeeping state
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wptr;
  logic [DEPTH_W-1:0] r_rptr;
  logic [DEPTH_W:0]   r_level;
  logic               r_overflow;

  // Handshake decode
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head_entry;

  // Status flags come from the registered occupancy only, so they carry no input path
  always_comb begin
    w_full  = (r_level == LVL_FULL);
    w_empty = (r_level == '0);
  end

  // Accept/pop decisions; a full buffer frees its head slot for a same-cycle push
  always_comb begin
    w_pop        = ~w_empty & out_ready_i;
    w_push       = push_i & (~w_full | w_pop);
    w_drop       = push_i & w_full & ~w_pop;
    w_push_entry = {push_addr_i, push_wdata_i, push_wstrb_i};
  end

  // Entry storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_entry;
    end
  end

  // Write pointer advances once per accepted push, wrapping modulo DEPTH
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= r_wptr + PTR_ONE;
    end
  end

  // Read pointer advances once per completed head transfer
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop cancel out
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky record of any dropped push, cleared only by reset
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Show-ahead head entry and status outputs
  always_comb begin
    w_head_entry = r_mem[r_rptr];
    out_addr_o   = w_head_entry[ENTRY_W-1 -: WADDR_W];
    out_wdata_o  = w_head_entry[NBYTES +: DATA_W];
    out_wstrb_o  = w_head_entry[NBYTES-1:0];
    out_valid_o  = ~w_empty;
    full_o       = w_full;
    empty_o      = w_empty;
    level_o      = r_level;
    overflow_o   = r_overflow;
  end

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Self-checking bench for iob_cache_write_buffer: directed scenarios followed by
// randomized traffic, scored against a queue-based reference model.
module tb_iob_cache_write_buffer;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH_W  = 2;
  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam int unsigned WADDR_W  = ADDR_W - $clog2(NBYTES);
  localparam int          DEPTH    = 2 ** DEPTH_W;

  typedef struct {
    logic [WADDR_W-1:0] a;
    logic [DATA_W-1:0]  d;
    logic [NBYTES-1:0]  s;
  } ent_t;

  logic               clk_i = 1'b0;
  logic               reset = 1'b1;
  logic               push_i = 1'b0;
  logic [WADDR_W-1:0] push_addr_i = '0;
  logic [DATA_W-1:0]  push_wdata_i = '0;
  logic [NBYTES-1:0]  push_wstrb_i = '0;
  logic               out_ready_i = 1'b0;
  logic               full_o;
  logic               empty_o;
  logic [DEPTH_W:0]   level_o;
  logic               overflow_o;
  logic               out_valid_o;
  logic [WADDR_W-1:0] out_addr_o;
  logic [DATA_W-1:0]  out_wdata_o;
  logic [NBYTES-1:0]  out_wstrb_o;

  // Reference model: queue of accepted entries plus the sticky overflow bit
  ent_t exp_q[$];
  int   mdl_cnt = 0;
  bit   mdl_ovf = 1'b0;

  int checks = 0;
  int failures = 0;

  iob_cache_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH_W(DEPTH_W)
  ) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .push_i      (push_i),
    .push_addr_i (push_addr_i),
    .push_wdata_i(push_wdata_i),
    .push_wstrb_i(push_wstrb_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .out_valid_o (out_valid_o),
    .out_addr_o  (out_addr_o),
    .out_wdata_o (out_wdata_o),
    .out_wstrb_o (out_wstrb_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same rising edge as the DUT
  task automatic cycle(input bit p, input logic [WADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NBYTES-1:0] s, input bit r);
    bit acc_push;
    bit acc_pop;
    ent_t e;
    push_i       = p;
    push_addr_i  = a;
    push_wdata_i = d;
    push_wstrb_i = s;
    out_ready_i  = r;
    acc_pop  = !reset && (mdl_cnt > 0) && r;
    acc_push = !reset && p && ((mdl_cnt < DEPTH) || acc_pop);
    e = '{a: a, d: d, s: s};
    @(posedge clk_i);
    if (!reset) begin
      if (acc_push) exp_q.push_back(e);
      mdl_cnt = mdl_cnt + int'(acc_push) - int'(acc_pop);
      if (p && !acc_push) mdl_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input bit r);
    cycle(1'b0, '0, '0, '0, r);
  endtask

  task automatic push(input logic [WADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit r);
    cycle(1'b1, a, d, NBYTES'($urandom), r);
  endtask

  // Reset mid-operation: state clears immediately, traffic during reset is ignored
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    #1;
    chk("rst_level", 64'(level_o), 64'(0));
    chk("rst_valid", 64'(out_valid_o), 64'(0));
    chk("rst_overflow", 64'(overflow_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_full", 64'(full_o), 64'(0));
    cycle(1'b1, WADDR_W'($urandom), DATA_W'($urandom), NBYTES'($urandom), 1'b1);
    cycle(1'b1, WADDR_W'($urandom), DATA_W'($urandom), NBYTES'($urandom), 1'b1);
    reset = 1'b0;
  endtask

  // Monitor: status every cycle, head entry against the scoreboard whenever valid
  always @(negedge clk_i) begin
    chk("level", 64'(level_o), 64'(mdl_cnt));
    chk("full", 64'(full_o), 64'(mdl_cnt == DEPTH));
    chk("empty", 64'(empty_o), 64'(mdl_cnt == 0));
    chk("out_valid", 64'(out_valid_o), 64'(mdl_cnt > 0));
    chk("overflow", 64'(overflow_o), 64'(mdl_ovf));
    if (out_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_entry", 64'(out_valid_o), 64'(0));
      end else begin
        chk("out_addr", 64'(out_addr_o), 64'(exp_q[0].a));
        chk("out_wdata", 64'(out_wdata_o), 64'(exp_q[0].d));
        chk("out_wstrb", 64'(out_wstrb_o), 64'(exp_q[0].s));
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int push_bias;
    int ready_bias;

    idle(1'b0);
    idle(1'b1);
    reset = 1'b0;
    idle(1'b0);

    // Three entries held at the head while the channel stalls
    push(22'h10, 32'hA, 1'b0);
    push(22'h11, 32'hB, 1'b0);
    push(22'h12, 32'hC, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("hold_level3", 64'(level_o), 64'(3));
    chk("hold_addr", 64'(out_addr_o), 64'(22'h10));
    chk("hold_wdata", 64'(out_wdata_o), 64'(32'hA));

    // Drain in order, then empty
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("drained_empty", 64'(empty_o), 64'(1));

    // Fill, then a dropped fifth push
    for (int i = 0; i < DEPTH; i++) push(WADDR_W'(32'h20 + i), DATA_W'(32'h1 + i), 1'b0);
    push(22'h3F, 32'hDEAD, 1'b0);
    idle(1'b0);
    chk("ovf_full", 64'(full_o), 64'(1));
    chk("ovf_flag", 64'(overflow_o), 64'(1));

    // Full with a same-cycle pop: push accepted, level stays DEPTH
    push(22'h2E, 32'hE, 1'b1);
    chk("full_pushpop_level", 64'(level_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    idle(1'b0);

    // Continuous push+pop across two pointer wraps
    push(22'h0, 32'h0, 1'b0);
    for (int i = 1; i < 10; i++) push(WADDR_W'(i), DATA_W'(i), 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Reset with three entries queued, then a single push
    for (int i = 0; i < 3; i++) push(WADDR_W'(32'h40 + i), DATA_W'(32'h50 + i), 1'b0);
    chk("pre_reset_level", 64'(level_o), 64'(3));
    do_reset();
    push(22'h77, 32'h77, 1'b0);
    chk("post_reset_level", 64'(level_o), 64'(1));
    cycle(1'b1, 22'h78, 32'h78, 4'h0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with shifting push/ready bias and occasional resets
    push_bias = 50;
    ready_bias = 50;
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) begin
        push_bias  = int'($urandom_range(10, 95));
        ready_bias = int'($urandom_range(10, 95));
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle(int'($urandom_range(0, 99)) < push_bias, WADDR_W'($urandom), DATA_W'($urandom),
              ($urandom_range(0, 7) == 0) ? '0 : NBYTES'($urandom),
              int'($urandom_range(0, 99)) < ready_bias);
      end
    end

    // Bounded drain of whatever is left
    for (int i = 0; i < 4 * DEPTH && mdl_cnt > 0; i++) idle(1'b1);
    idle(1'b0);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("final_empty", 64'(empty_o), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
